hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It sits beside the decode stage and tracks destination registers of in-flight instructions in a three-entry shadow pipeline (EX, MEM, WB). It decides each cycle whether the decode stage issues, stalls, bubbles or flushes. It also produces registered forwarding selects for the EX-stage ALU operands.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating stall and flush performance counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `id_valid` in 1: decode holds a real instruction.
- `id_rs1`, `id_rs2` in 5: source register fields.
- `id_use_rs1`, `id_use_rs2` in 1: operand is actually read.
- `id_rd` in 5: destination register.
- `id_reg_write`, `id_mem_read` in 1: decoded control bits.
- `ex_branch_taken` in 1: branch or jump resolved taken in EX this cycle.
- `mem_busy` in 1: data memory not ready; the whole pipe freezes.
- `pc_en`, `ifid_en` out 1: PC and IF/ID write enables.
- `ifid_flush`, `idex_bubble` out 1: clear IF/ID; load a NOP into ID/EX.
- `exmem_en`, `memwb_en` out 1: downstream pipeline-register enables.
- `fwd_a`, `fwd_b` out 2: EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- `id_byp_a`, `id_byp_b` out 1: select `wb_data` at decode. Present only with the macro (see Configuration).
- `hz_state` out 2: registered action of the previous cycle: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters.

## Operation
- Shadow entry fields: `v`, `rd`, `wr`, `ld`.
- A hazard match needs all of: `v`, `wr`, `rd != 0`, rd equal to the used source register. x0 never matches.
- Per-cycle decision, highest priority first:
  - FREEZE (`mem_busy`): all enables 0. No flush or bubble. Shadow and forward registers hold.
  - FLUSH (`ex_branch_taken`): `ifid_flush=1`, `idex_bubble=1`, pc_en/ifid_en=1 so the target is fetched. The shadow EX slot loads a bubble (v=0).
  - STALL (load-use): ID source matches the shadow EX entry and that entry has `ld=1`. pc_en=ifid_en=0, idex_bubble=1.
  - STALL (WB-retire, only without the macro): ID source matches the shadow WB entry. Same outputs as load-use.
  - RUN: all enables 1. The shadow EX slot loads {id_valid, id_rd, id_reg_write, id_mem_read}.
- The shadow shifts EX→MEM→WB on every non-FREEZE cycle. The old WB entry retires.
- Forward selects are computed at issue and registered into the EX cycle, per operand:
  - Match on shadow EX → 10.
  - Otherwise match on shadow MEM → 01.
  - Otherwise 00.
- When the cycle is a bubble or flush, the selects register 00.
- `stall_cnt` increments on each STALL cycle. `flush_cnt` increments on each FLUSH cycle. Both saturate at all-ones.

## Timing
- Enables, flush and bubble are combinational from inputs and shadow state in the same cycle.
- `fwd_*`, `hz_state` and the counters are registered with 1-cycle latency.
- A load-use stall lasts exactly 1 cycle. After the bubble, the load sits in MEM and forwarding selects 01.
- A taken branch costs 2 issue slots. Branch taken together with a load-use condition gives FLUSH, and no stall is counted.
- `mem_busy` together with a taken branch gives FREEZE. The flush is taken in the first cycle after `mem_busy` falls, provided `ex_branch_taken` is held, which EX guarantees because it is frozen.
- Reset values (while `reset`=0 at an edge):
  - All shadow entries v=0.
  - fwd=00, hz_state=RUN, counters=0, no bypass.
  - Combinational outputs during reset: enables 1, flush=bubble=0.
- Reset mid-stall aborts the stall. The following cycle is RUN.

## Configuration
- `HAZ_WB_BYPASS_EN` defined:
  - `id_byp_a`/`id_byp_b` exist. Each is asserted combinationally when the ID operand matches the shadow WB entry, so decode muxes `wb_data`.
  - There is no WB-retire stall.
- `HAZ_WB_BYPASS_EN` undefined:
  - The bypass ports are absent.
  - A WB-entry match causes a 1-cycle STALL, counted in `stall_cnt`.

## Structure
- Shared package holds:
  - `hz_state` encodings (RUN/STALL/FLUSH/FREEZE).
  - `fwd` select encodings (FWD_RF=00, FWD_MEM=01, FWD_EX=10).
  - Shadow entry struct {v, rd[4:0], wr, ld}.
- One sub-module, `hz_match`: takes one shadow entry plus rs and use, returns hit.

## Test plan
- `lw x5,0(x1)` then `add x6,x5,x2`: exactly one cycle with pc_en=0 and idex_bubble=1; then fwd_a=01 in the add's EX cycle; stall_cnt=1.
- `add x5,x1,x2` then `sub x7,x5,x5`: no stall; fwd_a=fwd_b=10.
- `addi x0,x0,1` then `add x3,x0,x0`, and load to x0 then use of x0: no stall, fwd=00.
- Taken `beq` in EX while the ID instruction is a load-use consumer: FLUSH, ifid_flush=idex_bubble=1, flush_cnt=1, stall_cnt unchanged.
- `mem_busy` high for 3 cycles with `ex_branch_taken`=1: three FREEZE cycles, all enables 0; flush on the 4th cycle; shadow unchanged across the freeze.
- Producer three instructions ahead of consumer (in WB):
  - With `HAZ_WB_BYPASS_EN`: id_byp=1, no stall.
  - Without it: 1 stall cycle.
  - Also assert `reset`=0 during a stall: next cycle is RUN, counters=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the decode-stage hazard controller: action encodings,
// forwarding select encodings and the shadow pipeline entry.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_STALL  = 2'd1,
    HZ_FLUSH  = 2'd2,
    HZ_FREEZE = 2'd3
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '0;

  // Youngest producer wins: EX/MEM result is newer than MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)       return FWD_EX;
    else if (hit_mem) return FWD_MEM;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_hz_match.sv
// Register dependency compare of one decode operand against one shadow entry.
// x0 never produces a dependency.
module hz_match
  import hazard_ctrl_pkg::*;
(
  input  shadow_t    entry,
  input  logic [4:0] rs,
  input  logic       use_rs,
  output logic       hit
);

  // The load flag does not take part in the match; callers qualify with it.
  logic unused_ld;
  assign unused_ld = entry.ld;

  // Dependency exists only for a live, writing, non-x0 producer of the used source.
  always_comb begin
    hit = use_rs && entry.v && entry.wr && (entry.rd != 5'd0) && (entry.rd == rs);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller beside the decode stage of the five-stage core.
// Tracks in-flight destinations in a three-entry shadow pipe (EX, MEM, WB),
// picks RUN / STALL / FLUSH / FREEZE each cycle and registers EX forwarding
// selects. Define HAZ_WB_BYPASS_EN to replace the WB-retire stall with a
// decode-stage wb_data bypass (id_byp_a / id_byp_b ports).
//
// state  | meaning
// RUN    | decode issues into EX
// STALL  | hold PC and IF/ID, bubble into EX (load-use or WB-retire)
// FLUSH  | taken branch in EX: clear IF/ID, bubble into EX, fetch target
// FREEZE | data memory busy: every pipeline register holds
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
`ifdef HAZ_WB_BYPASS_EN
  output logic             id_byp_a,
  output logic             id_byp_b,
`endif
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  shadow_t   sh_ex, sh_mem, sh_wb;
  hz_state_t act, hz_q;
  logic      use_a, use_b;
  logic      ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic      load_use, stall;

  // An invalid decode slot reads nothing, so it can never depend on anything.
  assign use_a = id_valid && id_use_rs1;
  assign use_b = id_valid && id_use_rs2;

  hz_match u_ex_a  (.entry(sh_ex),  .rs(id_rs1), .use_rs(use_a), .hit(ex_a));
  hz_match u_ex_b  (.entry(sh_ex),  .rs(id_rs2), .use_rs(use_b), .hit(ex_b));
  hz_match u_mem_a (.entry(sh_mem), .rs(id_rs1), .use_rs(use_a), .hit(mem_a));
  hz_match u_mem_b (.entry(sh_mem), .rs(id_rs2), .use_rs(use_b), .hit(mem_b));
  hz_match u_wb_a  (.entry(sh_wb),  .rs(id_rs1), .use_rs(use_a), .hit(wb_a));
  hz_match u_wb_b  (.entry(sh_wb),  .rs(id_rs2), .use_rs(use_b), .hit(wb_b));

  // Stall sources: load still in EX, or (without the bypass) a result retiring in WB.
  always_comb begin
    load_use = sh_ex.ld && (ex_a || ex_b);
`ifdef HAZ_WB_BYPASS_EN
    stall = load_use;
`else
    stall = load_use || wb_a || wb_b;
`endif
  end

  // Next action, highest priority first.
  always_comb begin
    act = HZ_RUN;
    if (mem_busy)             act = HZ_FREEZE;
    else if (ex_branch_taken) act = HZ_FLUSH;
    else if (stall)           act = HZ_STALL;
  end

  // Pipeline control outputs; reset forces a plain running pipe.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    if (reset) begin
      unique case (act)
        HZ_FREEZE: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end
        HZ_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        HZ_STALL: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZ_WB_BYPASS_EN
  // Decode takes wb_data directly when the operand's producer is retiring this cycle.
  always_comb begin
    id_byp_a = reset && wb_a;
    id_byp_b = reset && wb_b;
  end
`endif

  // Action register, visible as hz_state one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) hz_q <= HZ_RUN;
    else        hz_q <= act;
  end

  assign hz_state = hz_q;

  // Shadow pipe shifts on every non-frozen cycle; only RUN issues a real entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_ex  <= SHADOW_EMPTY;
      sh_mem <= SHADOW_EMPTY;
      sh_wb  <= SHADOW_EMPTY;
    end else if (act != HZ_FREEZE) begin
      sh_wb  <= sh_mem;
      sh_mem <= sh_ex;
      if (act == HZ_RUN) sh_ex <= '{v: id_valid, rd: id_rd, wr: id_reg_write, ld: id_mem_read};
      else               sh_ex <= SHADOW_EMPTY;
    end
  end

  // Forwarding selects follow the instruction into EX; bubbles carry regfile selects.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (act == HZ_RUN) begin
      fwd_a <= fwd_sel(ex_a, mem_a);
      fwd_b <= fwd_sel(ex_b, mem_b);
    end else if (act != HZ_FREEZE) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (act == HZ_STALL && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (act == HZ_FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed program fragments followed by
// randomized traffic, all compared each cycle against an in-bench model.
module tb_hazard_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          ex_branch_taken, mem_busy;
  logic          pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en;
  logic [1:0]    fwd_a, fwd_b, hz_state;
  logic [CW-1:0] stall_cnt, flush_cnt;
`ifdef HAZ_WB_BYPASS_EN
  logic          id_byp_a, id_byp_b;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
`ifdef HAZ_WB_BYPASS_EN
    .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
`endif
    .hz_state(hz_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Model: in-flight instructions by age (0 = in EX, 1 = MEM, 2 = WB).
  int m_v[3]  = '{0, 0, 0};
  int m_rd[3] = '{0, 0, 0};
  int m_wr[3] = '{0, 0, 0};
  int m_ld[3] = '{0, 0, 0};
  int m_fa = 0, m_fb = 0, m_hz = 0, m_ns = 0, m_nf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input int age, input int rs, input bit u);
    return u && m_v[age] != 0 && m_wr[age] != 0 && m_rd[age] != 0 && m_rd[age] == rs;
  endfunction

  // 0 run, 1 stall, 2 flush, 3 freeze
  function automatic int m_class();
    bit ua, ub, lu, wbs;
    ua  = id_valid && id_use_rs1;
    ub  = id_valid && id_use_rs2;
    lu  = m_ld[0] != 0 && (m_hit(0, id_rs1, ua) || m_hit(0, id_rs2, ub));
    wbs = m_hit(2, id_rs1, ua) || m_hit(2, id_rs2, ub);
`ifdef HAZ_WB_BYPASS_EN
    wbs = 1'b0;
`endif
    if (mem_busy)        return 3;
    if (ex_branch_taken) return 2;
    if (lu || wbs)       return 1;
    return 0;
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en}
  function automatic logic [5:0] m_ctl();
    if (!reset) return 6'b110011;
    case (m_class())
      3:       return 6'b000000;
      2:       return 6'b111111;
      1:       return 6'b000111;
      default: return 6'b110011;
    endcase
  endfunction

  function automatic int m_sel(input int rs, input bit u);
    if (m_hit(0, rs, u)) return 2;
    if (m_hit(1, rs, u)) return 1;
    return 0;
  endfunction

  task automatic m_clock();
    int c;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] = 0; m_rd[i] = 0; m_wr[i] = 0; m_ld[i] = 0;
      end
      m_fa = 0; m_fb = 0; m_hz = 0; m_ns = 0; m_nf = 0;
    end else begin
      c = m_class();
      m_hz = c;
      if (c != 3) begin
        if (c == 0) begin
          m_fa = m_sel(id_rs1, id_valid && id_use_rs1);
          m_fb = m_sel(id_rs2, id_valid && id_use_rs2);
        end else begin
          m_fa = 0; m_fb = 0;
        end
        if (c == 1) m_ns++;
        if (c == 2) m_nf++;
        for (int i = 2; i > 0; i--) begin
          m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_wr[i] = m_wr[i-1]; m_ld[i] = m_ld[i-1];
        end
        if (c == 0) begin
          m_v[0] = id_valid; m_rd[0] = id_rd; m_wr[0] = id_reg_write; m_ld[0] = id_mem_read;
        end else begin
          m_v[0] = 0; m_rd[0] = 0; m_wr[0] = 0; m_ld[0] = 0;
        end
      end
    end
  endtask

  // One clock: combinational checks mid-cycle, registered checks 1 unit after the edge.
  task automatic step();
    #2;
    chk("ctl", {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en}, m_ctl());
`ifdef HAZ_WB_BYPASS_EN
    chk("byp_a", id_byp_a, reset && m_hit(2, id_rs1, id_valid && id_use_rs1));
    chk("byp_b", id_byp_b, reset && m_hit(2, id_rs2, id_valid && id_use_rs2));
`endif
    @(posedge clk);
    m_clock();
    #1;
    chk("fwd_a", fwd_a, m_fa);
    chk("fwd_b", fwd_b, m_fb);
    chk("hz_state", hz_state, m_hz);
    chk("stall_cnt", stall_cnt, (m_ns > CMAX) ? CMAX : m_ns);
    chk("flush_cnt", flush_cnt, (m_nf > CMAX) ? CMAX : m_nf);
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit wr, input bit ld);
    id_valid = v;
    id_rs1 = 5'(rs1); id_use_rs1 = u1;
    id_rs2 = 5'(rs2); id_use_rs2 = u2;
    id_rd = 5'(rd); id_reg_write = wr; id_mem_read = ld;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_hz", hz_state, 0);
    chk("rst_fwd", fwd_a, 0);
    chk("rst_cnt", stall_cnt, 0);
    reset = 1'b1;
    idle(1);

    // lw x5,0(x1) ; add x6,x5,x2
    drive(1, 1, 1, 0, 0, 5, 1, 1); step();
    drive(1, 5, 1, 2, 1, 6, 1, 0);
    #1;
    chk("lu_pc_en", pc_en, 0);
    chk("lu_bubble", idex_bubble, 1);
    step();
    chk("lu_hz", hz_state, 1);
    step();
    chk("lu_fwd_a", fwd_a, 2'b01);
    chk("lu_fwd_b", fwd_b, 2'b00);
    chk("lu_stall_cnt", stall_cnt, 1);
    idle(4);

    // add x5,x1,x2 ; sub x7,x5,x5
    drive(1, 1, 1, 2, 1, 5, 1, 0); step();
    drive(1, 5, 1, 5, 1, 7, 1, 0); step();
    chk("ex_fwd_a", fwd_a, 2'b10);
    chk("ex_fwd_b", fwd_b, 2'b10);
    chk("ex_hz", hz_state, 0);
    idle(3);

    // x0 never creates a dependency
    drive(1, 0, 1, 0, 0, 0, 1, 0); step();
    drive(1, 0, 1, 0, 1, 3, 1, 0); step();
    chk("x0_fwd_a", fwd_a, 0);
    chk("x0_fwd_b", fwd_b, 0);
    drive(1, 1, 1, 0, 0, 0, 1, 1); step();
    drive(1, 0, 1, 0, 1, 4, 1, 0); step();
    chk("x0_ld_hz", hz_state, 0);
    chk("x0_ld_fwd", fwd_a, 0);
    chk("x0_stall_cnt", stall_cnt, 1);
    idle(3);

    // taken branch beats a load-use consumer
    drive(1, 1, 1, 0, 0, 8, 1, 1); step();
    drive(1, 8, 1, 8, 1, 9, 1, 0); ex_branch_taken = 1'b1;
    #1;
    chk("br_flush", ifid_flush, 1);
    chk("br_bubble", idex_bubble, 1);
    chk("br_pc_en", pc_en, 1);
    step();
    ex_branch_taken = 1'b0;
    chk("br_hz", hz_state, 2);
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 1);
    idle(3);

    // freeze for three cycles while a branch waits, then flush
    drive(1, 1, 1, 2, 1, 10, 1, 0); step();
    drive(1, 3, 1, 4, 1, 11, 1, 0);
    mem_busy = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_pc_en", pc_en, 0);
      chk("frz_exmem", exmem_en, 0);
      step();
      chk("frz_hz", hz_state, 3);
    end
    mem_busy = 1'b0;
    #1;
    chk("frz_then_flush", ifid_flush, 1);
    step();
    ex_branch_taken = 1'b0;
    chk("frz_flush_cnt", flush_cnt, 2);
    drive(1, 10, 1, 0, 0, 7, 1, 0); step();
    chk("frz_shadow_fwd", fwd_a, 2'b01);
    idle(3);

    // producer three ahead (reaches WB when the consumer decodes)
    drive(1, 1, 1, 0, 0, 12, 1, 0); step();
    idle(2);
    drive(1, 12, 1, 0, 0, 13, 1, 0);
`ifdef HAZ_WB_BYPASS_EN
    #1;
    chk("wb_byp", id_byp_a, 1);
    step();
    chk("wb_hz", hz_state, 0);
`else
    #1;
    chk("wb_pc_en", pc_en, 0);
    step();
    chk("wb_hz", hz_state, 1);
    chk("wb_stall_cnt", stall_cnt, 2);
    step();
    chk("wb_after_hz", hz_state, 0);
`endif
    idle(3);

    // reset in the middle of a stall
    drive(1, 1, 1, 0, 0, 14, 1, 0); step();
    idle(2);
    drive(1, 14, 1, 0, 0, 15, 1, 0);
    reset = 1'b0;
    #1;
    chk("rst_mid_pc_en", pc_en, 1);
    step();
    reset = 1'b1;
    chk("rst_mid_hz", hz_state, 0);
    chk("rst_mid_stall", stall_cnt, 0);
    chk("rst_mid_flush", flush_cnt, 0);
    #1;
    chk("rst_next_pc_en", pc_en, 1);
    step();
    chk("rst_next_hz", hz_state, 0);

    // randomized traffic over a small register set to provoke dependencies
    for (int n = 0; n < 3000; n++) begin
      bit v;
      reset = ($urandom_range(0, 149) != 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      v = ($urandom_range(0, 3) != 0);
      drive(v, $urandom_range(0, 7), v && $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), v && $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
